// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state encoding and configuration check for the UART transmitter
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   function automatic bit uart_cfg_ok(input int data_bits, input int stop_bits, input int bps_cnt);
      return (data_bits >= 5) && (data_bits <= 9) &&
             ((stop_bits == 1) || (stop_bits == 2)) &&
             (bps_cnt >= 2);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous show-ahead FIFO feeding the UART shift register
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes a full ring from an empty one.
   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (count == (AW + 1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter; UART_TX_BREAK_EN adds a tx_break line-break input
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_FRE    = 27_000_000,
   parameter int BPS        = 921600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                            sys_clk,
   input  logic                            sys_rst_n,
`ifdef UART_TX_BREAK_EN
   input  logic                            tx_break,
`endif
   input  logic [DATA_BITS-1:0]            tx_data,
   input  logic                            tx_valid,
   output logic                            tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            tx_busy,
   output logic                            tx_done,
   output logic                            uart_txd
);

   localparam int BPS_CNT = CLK_FRE / BPS;
   localparam int CW      = $clog2(BPS_CNT);

   localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
   localparam logic [2:0] S_START  = 3'(ST_START);
   localparam logic [2:0] S_DATA   = 3'(ST_DATA);
   localparam logic [2:0] S_PARITY = 3'(ST_PARITY);
   localparam logic [2:0] S_STOP   = 3'(ST_STOP);

   if (!uart_cfg_ok(DATA_BITS, STOP_BITS, BPS_CNT)) begin : g_cfg_err
      $error("uart_tx_buffered: illegal DATA_BITS, STOP_BITS or BPS_CNT");
   end

   logic [2:0]           state;
   logic [CW-1:0]        clk_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 par_bit;
   logic                 bit_end;
   logic                 stop_last;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_head;
   logic                 brk_req;
   logic                 brk_guard;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (tx_valid),
      .push_data (tx_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef UART_TX_BREAK_EN
   assign brk_req = tx_break;

   // After a break the line must idle high for one full bit time before the next start bit.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         brk_guard <= 1'b0;
      end else if (state == S_IDLE) begin
         if (tx_break)
            brk_guard <= 1'b1;
         else if (brk_guard && bit_end)
            brk_guard <= 1'b0;
      end
   end
`else
   assign brk_req   = 1'b0;
   assign brk_guard = 1'b0;
`endif

   assign tx_ready  = !fifo_full;
   assign tx_busy   = (state != S_IDLE);
   assign bit_end   = (clk_cnt == CW'(BPS_CNT - 1));
   assign stop_last = (state == S_STOP) && bit_end && (bit_cnt == 4'(STOP_BITS - 1));
   assign tx_done   = stop_last;

   always_comb begin
      fifo_pop = 1'b0;
      case (state)
         S_IDLE:  fifo_pop = !fifo_empty && !brk_req && !brk_guard;
         S_STOP:  fifo_pop = stop_last && !fifo_empty && !brk_req;
         default: fifo_pop = 1'b0;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= S_IDLE;
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         uart_txd <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               bit_cnt <= '0;
               if (brk_req) begin
                  uart_txd <= 1'b0;
                  clk_cnt  <= '0;
               end else if (brk_guard) begin
                  uart_txd <= 1'b1;
                  clk_cnt  <= bit_end ? '0 : clk_cnt + CW'(1);
               end else if (fifo_pop) begin
                  shift    <= fifo_head;
                  par_bit  <= (PARITY == PARITY_ODD) ? ~^fifo_head : ^fifo_head;
                  state    <= S_START;
                  uart_txd <= 1'b0;
                  clk_cnt  <= '0;
               end else begin
                  uart_txd <= 1'b1;
                  clk_cnt  <= '0;
               end
            end
            S_START: begin
               if (bit_end) begin
                  state    <= S_DATA;
                  uart_txd <= shift[0];
                  clk_cnt  <= '0;
                  bit_cnt  <= '0;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_cnt == 4'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     if (PARITY != PARITY_NONE) begin
                        state    <= S_PARITY;
                        uart_txd <= par_bit;
                     end else begin
                        state    <= S_STOP;
                        uart_txd <= 1'b1;
                     end
                  end else begin
                     bit_cnt  <= bit_cnt + 4'd1;
                     shift    <= shift >> 1;
                     uart_txd <= shift[1];
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  state    <= S_STOP;
                  uart_txd <= 1'b1;
                  clk_cnt  <= '0;
                  bit_cnt  <= '0;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_cnt == 4'(STOP_BITS - 1)) begin
                     bit_cnt <= '0;
                     // Chain straight into the next start bit when more data is queued.
                     if (fifo_pop) begin
                        shift    <= fifo_head;
                        par_bit  <= (PARITY == PARITY_ODD) ? ~^fifo_head : ^fifo_head;
                        state    <= S_START;
                        uart_txd <= 1'b0;
                     end else begin
                        state    <= S_IDLE;
                        uart_txd <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            default: begin
               state    <= S_IDLE;
               uart_txd <= 1'b1;
               clk_cnt  <= '0;
               bit_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed self-checking bench for uart_tx_buffered (four parameter sets)
module tb_uart_tx_buffered;

   localparam int BPS_CNT = 10;

   logic             sys_clk = 1'b0;
   logic             sys_rst_n = 1'b0;
   logic             brk = 1'b0;
   logic [3:0][7:0]  data = '0;
   logic [3:0]       valid = '0;
   logic [3:0]       ready;
   logic [3:0]       busy;
   logic [3:0]       done;
   logic [3:0]       txd;
   logic [3:0][2:0]  cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 sys_clk = ~sys_clk;

   // 0: 8N1, 1: 7E1, 2: 7O1, 3: 8N2
   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int DB = (g == 1 || g == 2) ? 7 : 8;
      uart_tx_buffered #(
         .CLK_FRE    (1_000_000),
         .BPS        (100_000),
         .DATA_BITS  (DB),
         .PARITY     (g == 1 ? 2 : (g == 2 ? 1 : 0)),
         .STOP_BITS  (g == 3 ? 2 : 1),
         .FIFO_DEPTH (4)
      ) u_dut (
         .sys_clk    (sys_clk),
         .sys_rst_n  (sys_rst_n),
`ifdef UART_TX_BREAK_EN
         .tx_break   (g == 0 ? brk : 1'b0),
`endif
         .tx_data    (data[g][DB-1:0]),
         .tx_valid   (valid[g]),
         .tx_ready   (ready[g]),
         .fifo_count (cnt[g]),
         .tx_busy    (busy[g]),
         .tx_done    (done[g]),
         .uart_txd   (txd[g])
      );
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void make_frame(input logic [7:0] d, input int db, input int par,
                                      input int sb, output logic [15:0] bits, output int n);
      logic x;
      bits = '0;
      x    = 1'b0;
      n    = 1;
      for (int i = 0; i < db; i++) begin
         bits[n] = d[i];
         x       = x ^ d[i];
         n++;
      end
      if (par == 1) begin bits[n] = ~x; n++; end
      if (par == 2) begin bits[n] = x;  n++; end
      for (int i = 0; i < sb; i++) begin bits[n] = 1'b1; n++; end
   endfunction

   task automatic push_word(input int k, input logic [7:0] d);
      data[k]  = d;
      valid[k] = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      valid[k] = 1'b0;
   endtask

   task automatic wait_start(input int k, input int budget, input string tag);
      int w;
      w = 0;
      while (txd[k] !== 1'b0 && w < budget) begin
         @(negedge sys_clk);
         w++;
      end
      check(tag, int'(txd[k] === 1'b0), 1);
   endtask

   // Entered on the first negedge showing the start bit; returns on the first cycle after the frame.
   task automatic check_frame(input int k, input logic [15:0] bits, input int n, input string tag);
      int good, bsy, dcnt, dat;
      bsy  = 0;
      dcnt = 0;
      dat  = -1;
      for (int b = 0; b < n; b++) begin
         good = 0;
         for (int c = 0; c < BPS_CNT; c++) begin
            if (txd[k] === bits[b]) good++;
            if (busy[k] === 1'b1) bsy++;
            if (done[k] === 1'b1) begin dcnt++; dat = b * BPS_CNT + c; end
            @(negedge sys_clk);
         end
         check($sformatf("%s_bit%0d", tag, b), good, BPS_CNT);
      end
      check({tag, "_busy"}, bsy, n * BPS_CNT);
      check({tag, "_done_cnt"}, dcnt, 1);
      check({tag, "_done_at"}, dat, n * BPS_CNT - 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] fb;
      int          fn;

      repeat (3) @(negedge sys_clk);
      check("rst_txd", txd, 4'hF);
      check("rst_ready", ready, 4'hF);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", cnt, 0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // single 8'hA5 frame, start bit one edge after acceptance
      push_word(0, 8'hA5);
      check("t1_pre_start_txd", txd[0], 1);
      check("t1_pre_start_count", cnt[0], 1);
      @(negedge sys_clk);
      check("t1_start_latency", txd[0], 0);
      check_frame(0, 16'(10'b1101001010), 10, "t1");
      check("t1_idle_txd", txd[0], 1);
      check("t1_idle_busy", busy[0], 0);
      repeat (5) @(negedge sys_clk);

      // burst of six words with tx_valid held, back-to-back frames
      fork
         begin
            int i, mx, bad, guard;
            logic rdy;
            i = 0; mx = 0; bad = 0; guard = 0;
            while (i < 6 && guard < 2000) begin
               data[0]  = 8'(i + 1);
               valid[0] = 1'b1;
               if (int'(cnt[0]) > mx) mx = int'(cnt[0]);
               if (ready[0] !== (cnt[0] != 3'd4)) bad++;
               rdy = ready[0];
               @(posedge sys_clk);
               @(negedge sys_clk);
               if (rdy) i++;
               guard++;
            end
            valid[0] = 1'b0;
            check("t2_pushed", i, 6);
            check("t2_max_count", mx, 4);
            check("t2_ready_vs_count", bad, 0);
         end
         begin
            wait_start(0, 10, "t2_first_start");
            for (int w = 0; w < 6; w++) begin
               make_frame(8'(w + 1), 8, 0, 1, fb, fn);
               check_frame(0, fb, fn, $sformatf("t2_w%0d", w + 1));
            end
         end
      join
      check("t2_idle_txd", txd[0], 1);
      check("t2_idle_busy", busy[0], 0);
      check("t2_idle_count", cnt[0], 0);

      // 7-bit 7'h07 with even and odd parity
      fork
         begin
            push_word(1, 8'h07);
            wait_start(1, 5, "t3e_start");
            check_frame(1, 16'(10'b1100001110), 10, "t3_even");
         end
         begin
            push_word(2, 8'h07);
            wait_start(2, 5, "t3o_start");
            check_frame(2, 16'(10'b1000001110), 10, "t3_odd");
         end
      join

      // two stop bits between consecutive frames
      push_word(3, 8'h81);
      push_word(3, 8'h7E);
      wait_start(3, 5, "t4_start");
      make_frame(8'h81, 8, 0, 2, fb, fn);
      check("t4_frame_len", fn, 11);
      check_frame(3, fb, fn, "t4_w1");
      make_frame(8'h7E, 8, 0, 2, fb, fn);
      check_frame(3, fb, fn, "t4_w2");
      check("t4_idle_busy", busy[3], 0);

      // reset during data bit 3 with two words queued
      begin
         int lo, dn, cn;
         push_word(0, 8'hC3);
         push_word(0, 8'h3C);
         push_word(0, 8'h5A);
         repeat (44) @(negedge sys_clk);
         check("t5_queued", cnt[0], 2);
         sys_rst_n = 1'b0;
         #1;
         check("t5_rst_txd", txd[0], 1);
         check("t5_rst_count", cnt[0], 0);
         check("t5_rst_busy", busy[0], 0);
         check("t5_rst_done", done[0], 0);
         @(negedge sys_clk);
         @(negedge sys_clk);
         sys_rst_n = 1'b1;
         lo = 0; dn = 0; cn = 0;
         for (int c = 0; c < 300; c++) begin
            @(negedge sys_clk);
            if (txd[0] !== 1'b1) lo++;
            if (done[0] !== 1'b0) dn++;
            if (cnt[0] !== 3'd0) cn++;
         end
         check("t5_no_frame_after_rst", lo, 0);
         check("t5_no_done_after_rst", dn, 0);
         check("t5_fifo_stays_empty", cn, 0);
      end

`ifdef UART_TX_BREAK_EN
      // break during frame 1 of 2
      begin
         int lo, hi;
         push_word(0, 8'h55);
         push_word(0, 8'hAA);
         wait_start(0, 5, "t6_start");
         make_frame(8'h55, 8, 0, 1, fb, fn);
         fork
            check_frame(0, fb, fn, "t6_w1");
            begin
               repeat (30) @(negedge sys_clk);
               brk = 1'b1;
            end
         join
         @(negedge sys_clk);
         lo = 0;
         for (int c = 0; c < 20; c++) begin
            if (txd[0] === 1'b0) lo++;
            @(negedge sys_clk);
         end
         check("t6_break_low", lo, 20);
         check("t6_break_no_pop", cnt[0], 1);
         brk = 1'b0;
         @(negedge sys_clk);
         hi = 0;
         while (txd[0] === 1'b1 && hi < 100) begin
            hi++;
            @(negedge sys_clk);
         end
         check("t6_release_high_min", int'(hi >= BPS_CNT), 1);
         check("t6_release_restart", int'(hi < 100), 1);
         make_frame(8'hAA, 8, 0, 1, fb, fn);
         check_frame(0, fb, fn, "t6_w2");
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
